axil_reg_arbiter: RTL and testbench
===================================

AXIL_REG_ARBITER -- requirements
Module: axil_reg_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 The block SHALL have parameter ADDR_W, default 32, meaning the AXI4-Lite address width.
REQ-003 The block SHALL have parameter DATA_W, default 32, meaning the AXI4-Lite data width; only 32 is supported.
REQ-004 The block SHALL have port ACLK, input, 1 bit: the clock.
REQ-005 The block SHALL have port ARESET, input, 1 bit: the asynchronous active-high reset.
REQ-006 The block SHALL have port req_valid, input, 2 bits: per-requester command valid; bit 0 is requester 0.
REQ-007 The block SHALL have port req_ready, output, 2 bits: per-requester command accept, a one-cycle pulse.
REQ-008 The block SHALL have port req_wr, input, 2 bits: 1 = write, 0 = read.
REQ-009 The block SHALL have port req_addr, input, 2*ADDR_W bits: requester n uses slice [n*ADDR_W +: ADDR_W].
REQ-010 The block SHALL have port req_wdata, input, 2*DATA_W bits: write data, sliced as for req_addr.
REQ-011 The block SHALL have port resp_valid, output, 2 bits: per-requester completion pulse.
REQ-012 The block SHALL have port resp_rdata, output, DATA_W bits: read data; 0 for writes.
REQ-013 The block SHALL have port resp_err, output, 1 bit: 1 when the response is not OKAY or the address is misaligned.
REQ-014 The block SHALL have ports M_AXI_AWADDR (out, ADDR_W), M_AXI_AWPROT (out, 3), M_AXI_AWVALID (out, 1) and M_AXI_AWREADY (in, 1), forming the AXI4-Lite write-address channel.
REQ-015 The block SHALL have ports M_AXI_WDATA (out, DATA_W), M_AXI_WSTRB (out, DATA_W/8), M_AXI_WVALID (out, 1) and M_AXI_WREADY (in, 1), forming the write-data channel.
REQ-016 The block SHALL have ports M_AXI_BRESP (in, 2), M_AXI_BVALID (in, 1) and M_AXI_BREADY (out, 1), forming the write-response channel.
REQ-017 The block SHALL have ports M_AXI_ARADDR (out, ADDR_W), M_AXI_ARPROT (out, 3), M_AXI_ARVALID (out, 1) and M_AXI_ARREADY (in, 1), forming the read-address channel.
REQ-018 The block SHALL have ports M_AXI_RDATA (in, DATA_W), M_AXI_RRESP (in, 2), M_AXI_RVALID (in, 1) and M_AXI_RREADY (out, 1), forming the read-data channel.

Function
REQ-019 The block SHALL use an FSM with states IDLE, WR, WB, RA, RD and RSP, and SHALL allow at most one transaction outstanding.
REQ-020 In IDLE with any req_valid set, the block SHALL grant round-robin: the requester not in last_grant wins a tie, and a single requester wins immediately.
REQ-021 The grant cycle SHALL pulse req_ready[g], register the command, and update last_grant to g.
REQ-022 For a misaligned address (addr[1:0] != 0), the block SHALL issue no bus transaction, go to RSP, and report resp_err=1 with resp_rdata=0.
REQ-023 For a write, the block SHALL raise AWVALID and WVALID together in the cycle after the grant.
REQ-024 Each of AWVALID and WVALID SHALL drop independently after its own handshake, and the block SHALL enter WB when both handshakes are done, including when both occur in the same cycle.
REQ-025 In WB, BREADY SHALL be 1; on BVALID the block SHALL capture resp_err = (BRESP != OKAY) and go to RSP.
REQ-026 For a read, the block SHALL raise ARVALID in the cycle after the grant and hold it until ARREADY, then enter RD.
REQ-027 In RD, RREADY SHALL be 1; on RVALID the block SHALL capture RDATA and resp_err = (RRESP != OKAY) and go to RSP.
REQ-028 In RSP, the block SHALL pulse resp_valid[g] for one cycle with resp_rdata and resp_err stable, then return to IDLE.
REQ-029 The earliest next grant SHALL be the cycle after RSP.
REQ-030 WSTRB SHALL be all ones and AWPROT/ARPROT SHALL be 3'b000.
REQ-031 Address and data SHALL be passed unchanged from the registered command.
REQ-032 With zero-wait slave ready/valid, the latency from grant to resp_valid SHALL be 4 cycles.
REQ-033 Requesters hold req_valid and payload until req_ready; the block SHALL NOT support withdrawal of a request.
REQ-034 VALID signals SHALL never depend combinationally on READY inputs.

Reset
REQ-035 ARESET=1 SHALL asynchronously force state IDLE; all VALID/READY outputs, req_ready, resp_valid, resp_rdata and resp_err to 0; AXI address and data outputs to 0; and last_grant=1 (requester 0 wins first).
REQ-036 On reset mid-transaction, the block SHALL drop the transaction with no response issued.

Structure
REQ-037 Package axil_arb_pkg SHALL hold the FSM state typedef, RESP_OKAY=2'b00, RESP_SLVERR=2'b10 and PROT_DEFAULT=3'b000.
REQ-038 The design SHALL contain one sub-module, rr_arb2: a 2-way round-robin grant from the request vector and last_grant.

Verification
REQ-039 Single write: r0 writes 0x0101FFFF to 0x0, slave always ready, BRESP=OKAY -> AWVALID=WVALID=1 at grant+1, resp_valid[0] at grant+4, resp_err=0.
REQ-040 Simultaneous requests after reset: r0 write 0xabcd0001 @0x4 and r1 read @0x4 -> r0 granted first, r1 granted the cycle after r0's RSP, r1 resp_rdata=0xabcd0001.
REQ-041 AWREADY immediate, WREADY delayed 3 cycles -> AWVALID low after 1 cycle, WVALID held 4 cycles, BREADY rises only after the W handshake.
REQ-042 Read @0x8 with RRESP=2'b10 and RDATA=0xdead0011 -> resp_err=1, resp_rdata=0xdead0011.
REQ-043 r1 read @0x6 -> no ARVALID, resp_valid[1] two cycles after grant, resp_err=1.
REQ-044 ARESET asserted in RD -> outputs 0 within the same cycle with no clock edge, no resp_valid; the next simultaneous request is granted to r0.

Source files
------------

// File: rtl/axil_arb_pkg.sv
// ----------------------------------------------------------------------------
// axil_arb_pkg
// Shared types and constants for the two-requester AXI4-Lite register
// arbiter.
//   arb_state_t     : controller FSM states
//   RESP_OKAY       : AXI response code for a successful access
//   RESP_SLVERR     : AXI response code for a slave error
//   PROT_DEFAULT    : protection attributes driven on AWPROT/ARPROT
//   grant_onehot    : index-to-one-hot conversion for a 2-way grant
//   addr_misaligned : true when a 32-bit access is not word aligned
// ----------------------------------------------------------------------------
package axil_arb_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR   = 3'd1,
    WB   = 3'd2,
    RA   = 3'd3,
    RD   = 3'd4,
    RSP  = 3'd5
  } arb_state_t;

  localparam logic [1:0] RESP_OKAY    = 2'b00;
  localparam logic [1:0] RESP_SLVERR  = 2'b10;
  localparam logic [2:0] PROT_DEFAULT = 3'b000;

  function automatic logic [1:0] grant_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

  function automatic logic addr_misaligned(input logic [1:0] lsbs);
    return lsbs != 2'b00;
  endfunction

endpackage

// File: rtl/axil_reg_arbiter_rr_arb2.sv
// ----------------------------------------------------------------------------
// rr_arb2
// Purely combinational 2-way round-robin pick. When both requesters are
// asking, the one that did not win last time is chosen; a lone requester
// always wins.
//   i_req        : request vector, bit n is requester n
//   i_last_grant : index of the requester granted most recently
//   o_valid      : at least one request is present
//   o_idx        : index of the chosen requester (meaningful when o_valid)
// ----------------------------------------------------------------------------
module rr_arb2 (
  input  logic [1:0] i_req,
  input  logic       i_last_grant,
  output logic       o_valid,
  output logic       o_idx
);

  // A tie alternates away from the previous winner.
  always_comb begin
    o_valid = |i_req;
    o_idx   = 1'b0;
    case (i_req)
      2'b11:   o_idx = ~i_last_grant;
      2'b10:   o_idx = 1'b1;
      default: o_idx = 1'b0;
    endcase
  end

endmodule

// File: rtl/axil_reg_arbiter.sv
// ----------------------------------------------------------------------------
// axil_reg_arbiter
// Shares one AXI4-Lite master port between two simple command requesters.
// Only one transaction is in flight at a time: a requester is granted in
// IDLE, its command is registered, the matching AXI channels are driven, and
// the outcome is returned on resp_valid/resp_rdata/resp_err.
//
// Ports
//   ACLK, ARESET            : clock, asynchronous active-high reset
//   req_valid/req_ready     : per-requester command handshake (ready pulses)
//   req_wr                  : 1 = write, 0 = read, per requester
//   req_addr/req_wdata      : packed per-requester address and write data
//   resp_valid              : per-requester completion pulse
//   resp_rdata/resp_err     : read data (0 for writes) and error flag
//   M_AXI_*                 : AXI4-Lite master (AW, W, B, AR, R channels)
//
// The response stage is registered out of RSP, so resp_valid appears the
// cycle after the FSM passes through RSP. That gives grant-to-response
// latency of 4 cycles on a zero-wait slave and 2 cycles for a rejected
// misaligned command, while a new grant may already happen in that cycle.
// Only DATA_W = 32 is supported.
// ----------------------------------------------------------------------------
module axil_reg_arbiter
  import axil_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  ACLK,
  input  logic                  ARESET,

  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [1:0]            req_wr,
  input  logic [2*ADDR_W-1:0]   req_addr,
  input  logic [2*DATA_W-1:0]   req_wdata,

  output logic [1:0]            resp_valid,
  output logic [DATA_W-1:0]     resp_rdata,
  output logic                  resp_err,

  output logic [ADDR_W-1:0]     M_AXI_AWADDR,
  output logic [2:0]            M_AXI_AWPROT,
  output logic                  M_AXI_AWVALID,
  input  logic                  M_AXI_AWREADY,

  output logic [DATA_W-1:0]     M_AXI_WDATA,
  output logic [DATA_W/8-1:0]   M_AXI_WSTRB,
  output logic                  M_AXI_WVALID,
  input  logic                  M_AXI_WREADY,

  input  logic [1:0]            M_AXI_BRESP,
  input  logic                  M_AXI_BVALID,
  output logic                  M_AXI_BREADY,

  output logic [ADDR_W-1:0]     M_AXI_ARADDR,
  output logic [2:0]            M_AXI_ARPROT,
  output logic                  M_AXI_ARVALID,
  input  logic                  M_AXI_ARREADY,

  input  logic [DATA_W-1:0]     M_AXI_RDATA,
  input  logic [1:0]            M_AXI_RRESP,
  input  logic                  M_AXI_RVALID,
  output logic                  M_AXI_RREADY
);

  arb_state_t r_state;
  arb_state_t w_next_state;

  logic              r_last_grant;
  logic              r_gnt;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_awvalid;
  logic              r_wvalid;
  logic              r_arvalid;
  logic [DATA_W-1:0] r_cap_rdata;
  logic              r_cap_err;
  logic [1:0]        r_resp_valid;
  logic [DATA_W-1:0] r_resp_rdata;
  logic              r_resp_err;

  logic              w_gnt_valid;
  logic              w_gnt_idx;
  logic              w_grant;
  logic              w_sel_wr;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;
  logic              w_sel_misaligned;
  logic              w_aw_done;
  logic              w_w_done;

  rr_arb2 u_rr_arb2 (
    .i_req        (req_valid),
    .i_last_grant (r_last_grant),
    .o_valid      (w_gnt_valid),
    .o_idx        (w_gnt_idx)
  );

  // Arbitration only happens while idle; the winner's payload is muxed out
  // of the packed request buses for registering.
  assign w_grant          = (r_state == IDLE) && w_gnt_valid;
  assign w_sel_wr         = req_wr[w_gnt_idx];
  assign w_sel_addr       = w_gnt_idx ? req_addr[2*ADDR_W-1:ADDR_W]
                                      : req_addr[ADDR_W-1:0];
  assign w_sel_wdata      = w_gnt_idx ? req_wdata[2*DATA_W-1:DATA_W]
                                      : req_wdata[DATA_W-1:0];
  assign w_sel_misaligned = addr_misaligned(w_sel_addr[1:0]);

  // A write channel counts as finished once its VALID has already dropped
  // or its handshake is happening this cycle, so AW and W may complete in
  // either order or together.
  assign w_aw_done = !r_awvalid || M_AXI_AWREADY;
  assign w_w_done  = !r_wvalid  || M_AXI_WREADY;

  // FSM state register.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic. Misaligned commands skip the bus entirely.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_gnt_valid) begin
          if (w_sel_misaligned) begin
            w_next_state = RSP;
          end else if (w_sel_wr) begin
            w_next_state = WR;
          end else begin
            w_next_state = RA;
          end
        end
      end
      WR: begin
        if (w_aw_done && w_w_done) begin
          w_next_state = WB;
        end
      end
      WB: begin
        if (M_AXI_BVALID) begin
          w_next_state = RSP;
        end
      end
      RA: begin
        if (M_AXI_ARREADY) begin
          w_next_state = RD;
        end
      end
      RD: begin
        if (M_AXI_RVALID) begin
          w_next_state = RSP;
        end
      end
      RSP: begin
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Command capture, AXI VALID generation and result capture. The VALIDs are
  // registers so they never follow the slave READYs combinationally.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_last_grant <= 1'b1;
      r_gnt        <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_awvalid    <= 1'b0;
      r_wvalid     <= 1'b0;
      r_arvalid    <= 1'b0;
      r_cap_rdata  <= '0;
      r_cap_err    <= 1'b0;
    end else begin
      if (w_grant) begin
        r_gnt        <= w_gnt_idx;
        r_last_grant <= w_gnt_idx;
        r_addr       <= w_sel_addr;
        r_wdata      <= w_sel_wdata;
        r_awvalid    <= w_sel_wr && !w_sel_misaligned;
        r_wvalid     <= w_sel_wr && !w_sel_misaligned;
        r_arvalid    <= !w_sel_wr && !w_sel_misaligned;
        r_cap_rdata  <= '0;
        r_cap_err    <= w_sel_misaligned;
      end else begin
        if (r_awvalid && M_AXI_AWREADY) begin
          r_awvalid <= 1'b0;
        end
        if (r_wvalid && M_AXI_WREADY) begin
          r_wvalid <= 1'b0;
        end
        if (r_arvalid && M_AXI_ARREADY) begin
          r_arvalid <= 1'b0;
        end
        if ((r_state == WB) && M_AXI_BVALID) begin
          r_cap_err <= (M_AXI_BRESP != RESP_OKAY);
        end
        if ((r_state == RD) && M_AXI_RVALID) begin
          r_cap_rdata <= M_AXI_RDATA;
          r_cap_err   <= (M_AXI_RRESP != RESP_OKAY);
        end
      end
    end
  end

  // Response output stage: a single-cycle resp_valid pulse driven out of
  // RSP. Data and error hold their value afterwards so they stay stable for
  // the whole pulse.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_resp_valid <= 2'b00;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
    end else begin
      if (r_state == RSP) begin
        r_resp_valid <= grant_onehot(r_gnt);
        r_resp_rdata <= r_cap_rdata;
        r_resp_err   <= r_cap_err;
      end else begin
        r_resp_valid <= 2'b00;
      end
    end
  end

  assign req_ready  = w_grant ? grant_onehot(w_gnt_idx) : 2'b00;

  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;

  assign M_AXI_AWADDR  = r_addr;
  assign M_AXI_AWPROT  = PROT_DEFAULT;
  assign M_AXI_AWVALID = r_awvalid;

  assign M_AXI_WDATA   = r_wdata;
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_WVALID  = r_wvalid;

  assign M_AXI_BREADY  = (r_state == WB);

  assign M_AXI_ARADDR  = r_addr;
  assign M_AXI_ARPROT  = PROT_DEFAULT;
  assign M_AXI_ARVALID = r_arvalid;

  assign M_AXI_RREADY  = (r_state == RD);

endmodule

// File: tb/tb_axil_reg_arbiter.sv
// ----------------------------------------------------------------------------
// tb_axil_reg_arbiter
// Directed bench for axil_reg_arbiter with a small register-file slave model
// whose ready delays and response codes are adjustable per scenario.
// ----------------------------------------------------------------------------
module tb_axil_reg_arbiter;
  import axil_arb_pkg::*;

  logic        ACLK;
  logic        ARESET;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  req_wr;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [1:0]  resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  logic [31:0] M_AXI_AWADDR;
  logic [2:0]  M_AXI_AWPROT;
  logic        M_AXI_AWVALID;
  logic        M_AXI_AWREADY;
  logic [31:0] M_AXI_WDATA;
  logic [3:0]  M_AXI_WSTRB;
  logic        M_AXI_WVALID;
  logic        M_AXI_WREADY;
  logic [1:0]  M_AXI_BRESP;
  logic        M_AXI_BVALID;
  logic        M_AXI_BREADY;
  logic [31:0] M_AXI_ARADDR;
  logic [2:0]  M_AXI_ARPROT;
  logic        M_AXI_ARVALID;
  logic        M_AXI_ARREADY;
  logic [31:0] M_AXI_RDATA;
  logic [1:0]  M_AXI_RRESP;
  logic        M_AXI_RVALID;
  logic        M_AXI_RREADY;

  int compared   = 0;
  int mismatched = 0;

  // Slave model configuration, set by the scenario tasks.
  int          awDelay   = 0;
  int          wDelay    = 0;
  logic [1:0]  bRespCfg  = RESP_OKAY;
  logic [1:0]  rRespCfg  = RESP_OKAY;
  logic        useRdOvr  = 1'b0;
  logic [31:0] rdOvr     = 32'h0;
  logic        stallR    = 1'b0;

  logic [31:0] mem [16];

  axil_reg_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .ACLK          (ACLK),
    .ARESET        (ARESET),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_wr        (req_wr),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .resp_valid    (resp_valid),
    .resp_rdata    (resp_rdata),
    .resp_err      (resp_err),
    .M_AXI_AWADDR  (M_AXI_AWADDR),
    .M_AXI_AWPROT  (M_AXI_AWPROT),
    .M_AXI_AWVALID (M_AXI_AWVALID),
    .M_AXI_AWREADY (M_AXI_AWREADY),
    .M_AXI_WDATA   (M_AXI_WDATA),
    .M_AXI_WSTRB   (M_AXI_WSTRB),
    .M_AXI_WVALID  (M_AXI_WVALID),
    .M_AXI_WREADY  (M_AXI_WREADY),
    .M_AXI_BRESP   (M_AXI_BRESP),
    .M_AXI_BVALID  (M_AXI_BVALID),
    .M_AXI_BREADY  (M_AXI_BREADY),
    .M_AXI_ARADDR  (M_AXI_ARADDR),
    .M_AXI_ARPROT  (M_AXI_ARPROT),
    .M_AXI_ARVALID (M_AXI_ARVALID),
    .M_AXI_ARREADY (M_AXI_ARREADY),
    .M_AXI_RDATA   (M_AXI_RDATA),
    .M_AXI_RRESP   (M_AXI_RRESP),
    .M_AXI_RVALID  (M_AXI_RVALID),
    .M_AXI_RREADY  (M_AXI_RREADY)
  );

  // 100 MHz clock.
  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  // Slave model: decides its ready/valid outputs on the falling edge so the
  // DUT sees them settled at the next rising edge.
  initial begin
    logic [31:0] lastAwAddr;
    logic [31:0] lastWdata;
    logic [31:0] lastArAddr;
    int awCnt;
    int wCnt;
    lastAwAddr = 32'h0;
    lastWdata  = 32'h0;
    lastArAddr = 32'h0;
    awCnt = 0;
    wCnt  = 0;
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    M_AXI_AWREADY = 1'b0;
    M_AXI_WREADY  = 1'b0;
    M_AXI_BRESP   = RESP_OKAY;
    M_AXI_BVALID  = 1'b0;
    M_AXI_ARREADY = 1'b0;
    M_AXI_RDATA   = 32'h0;
    M_AXI_RRESP   = RESP_OKAY;
    M_AXI_RVALID  = 1'b0;
    forever begin
      @(negedge ACLK);
      if (M_AXI_AWVALID) begin
        lastAwAddr = M_AXI_AWADDR;
        if (awCnt >= awDelay) M_AXI_AWREADY = 1'b1;
        else begin M_AXI_AWREADY = 1'b0; awCnt++; end
      end else begin
        M_AXI_AWREADY = 1'b0;
        awCnt = 0;
      end
      if (M_AXI_WVALID) begin
        lastWdata = M_AXI_WDATA;
        if (wCnt >= wDelay) M_AXI_WREADY = 1'b1;
        else begin M_AXI_WREADY = 1'b0; wCnt++; end
      end else begin
        M_AXI_WREADY = 1'b0;
        wCnt = 0;
      end
      if (M_AXI_BREADY && !M_AXI_BVALID) begin
        M_AXI_BVALID = 1'b1;
        M_AXI_BRESP  = bRespCfg;
        mem[lastAwAddr[5:2]] = lastWdata;
      end else begin
        M_AXI_BVALID = 1'b0;
      end
      if (M_AXI_ARVALID) begin
        lastArAddr    = M_AXI_ARADDR;
        M_AXI_ARREADY = 1'b1;
      end else begin
        M_AXI_ARREADY = 1'b0;
      end
      if (M_AXI_RREADY && !M_AXI_RVALID && !stallR) begin
        M_AXI_RVALID = 1'b1;
        M_AXI_RDATA  = useRdOvr ? rdOvr : mem[lastArAddr[5:2]];
        M_AXI_RRESP  = rRespCfg;
      end else begin
        M_AXI_RVALID = 1'b0;
        M_AXI_RDATA  = 32'h0;
      end
    end
  end

  // Hard stop in case a scenario loses track of the DUT.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] valid, input logic [1:0] wr,
                               input logic [31:0] a0, input logic [31:0] a1,
                               input logic [31:0] d0, input logic [31:0] d1);
    req_valid = valid;
    req_wr    = wr;
    req_addr  = {a1, a0};
    req_wdata = {d1, d0};
  endtask

  // Reset state of every output.
  task automatic test_reset();
    $display("[TB] reset");
    ARESET = 1'b1;
    applyStimulus(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    tick(); tick();
    compared++; if (req_ready !== 2'b00) begin mismatched++; $display("[TB] FAIL rst_req_ready: got %h expected %h", req_ready, 2'b00); end
    compared++; if (resp_valid !== 2'b00) begin mismatched++; $display("[TB] FAIL rst_resp_valid: got %h expected %h", resp_valid, 2'b00); end
    compared++; if (resp_rdata !== 32'h0) begin mismatched++; $display("[TB] FAIL rst_resp_rdata: got %h expected %h", resp_rdata, 32'h0); end
    compared++; if (resp_err !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_resp_err: got %h expected %h", resp_err, 1'b0); end
    compared++; if ({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID, M_AXI_BREADY, M_AXI_RREADY} !== 5'b0) begin mismatched++; $display("[TB] FAIL rst_axi_handshake: got %b expected %b", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID, M_AXI_BREADY, M_AXI_RREADY}, 5'b0); end
    compared++; if ({M_AXI_AWADDR, M_AXI_WDATA} !== 64'h0) begin mismatched++; $display("[TB] FAIL rst_axi_addr_data: got %h expected %h", {M_AXI_AWADDR, M_AXI_WDATA}, 64'h0); end
    ARESET = 1'b0;
    tick();
  endtask

  // r0 writes 0x0101FFFF to 0x0 on a zero-wait slave.
  task automatic test_single_write();
    $display("[TB] single write");
    applyStimulus(2'b01, 2'b01, 32'h0, 32'h0, 32'h0101FFFF, 32'h0);
    #1;
    compared++; if (req_ready !== 2'b01) begin mismatched++; $display("[TB] FAIL sw_grant: got %h expected %h", req_ready, 2'b01); end
    tick();
    applyStimulus(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    compared++; if ({M_AXI_AWVALID, M_AXI_WVALID} !== 2'b11) begin mismatched++; $display("[TB] FAIL sw_aw_w_valid: got %b expected %b", {M_AXI_AWVALID, M_AXI_WVALID}, 2'b11); end
    compared++; if (M_AXI_AWADDR !== 32'h0) begin mismatched++; $display("[TB] FAIL sw_awaddr: got %h expected %h", M_AXI_AWADDR, 32'h0); end
    compared++; if (M_AXI_WDATA !== 32'h0101FFFF) begin mismatched++; $display("[TB] FAIL sw_wdata: got %h expected %h", M_AXI_WDATA, 32'h0101FFFF); end
    compared++; if (M_AXI_WSTRB !== 4'hF) begin mismatched++; $display("[TB] FAIL sw_wstrb: got %h expected %h", M_AXI_WSTRB, 4'hF); end
    compared++; if (M_AXI_AWPROT !== 3'b000) begin mismatched++; $display("[TB] FAIL sw_awprot: got %h expected %h", M_AXI_AWPROT, 3'b000); end
    tick();
    compared++; if ({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY} !== 3'b001) begin mismatched++; $display("[TB] FAIL sw_wb_phase: got %b expected %b", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY}, 3'b001); end
    tick();
    compared++; if (resp_valid !== 2'b00) begin mismatched++; $display("[TB] FAIL sw_resp_early: got %h expected %h", resp_valid, 2'b00); end
    tick();
    compared++; if (resp_valid !== 2'b01) begin mismatched++; $display("[TB] FAIL sw_resp_valid: got %h expected %h", resp_valid, 2'b01); end
    compared++; if (resp_err !== 1'b0) begin mismatched++; $display("[TB] FAIL sw_resp_err: got %h expected %h", resp_err, 1'b0); end
    compared++; if (resp_rdata !== 32'h0) begin mismatched++; $display("[TB] FAIL sw_resp_rdata: got %h expected %h", resp_rdata, 32'h0); end
    compared++; if (mem[0] !== 32'h0101FFFF) begin mismatched++; $display("[TB] FAIL sw_slave_mem: got %h expected %h", mem[0], 32'h0101FFFF); end
    tick();
    compared++; if (resp_valid !== 2'b00) begin mismatched++; $display("[TB] FAIL sw_resp_pulse: got %h expected %h", resp_valid, 2'b00); end
  endtask

  // After reset, r0 write and r1 read to 0x4 arrive together.
  task automatic test_simultaneous();
    $display("[TB] simultaneous requests");
    ARESET = 1'b1;
    tick();
    ARESET = 1'b0;
    tick();
    applyStimulus(2'b11, 2'b01, 32'h4, 32'h4, 32'hABCD0001, 32'h0);
    #1;
    compared++; if (req_ready !== 2'b01) begin mismatched++; $display("[TB] FAIL sim_first_grant: got %h expected %h", req_ready, 2'b01); end
    tick();
    applyStimulus(2'b10, 2'b00, 32'h0, 32'h4, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      compared++; if (req_ready !== 2'b00) begin mismatched++; $display("[TB] FAIL sim_busy_ready%0d: got %h expected %h", i, req_ready, 2'b00); end
      tick();
    end
    compared++; if (req_ready !== 2'b10) begin mismatched++; $display("[TB] FAIL sim_second_grant: got %h expected %h", req_ready, 2'b10); end
    compared++; if (resp_valid !== 2'b01) begin mismatched++; $display("[TB] FAIL sim_r0_resp: got %h expected %h", resp_valid, 2'b01); end
    tick();
    applyStimulus(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    compared++; if ({M_AXI_ARVALID, M_AXI_ARADDR} !== {1'b1, 32'h4}) begin mismatched++; $display("[TB] FAIL sim_ar: got %h expected %h", {M_AXI_ARVALID, M_AXI_ARADDR}, {1'b1, 32'h4}); end
    tick(); tick(); tick();
    compared++; if (resp_valid !== 2'b10) begin mismatched++; $display("[TB] FAIL sim_r1_resp: got %h expected %h", resp_valid, 2'b10); end
    compared++; if (resp_rdata !== 32'hABCD0001) begin mismatched++; $display("[TB] FAIL sim_r1_rdata: got %h expected %h", resp_rdata, 32'hABCD0001); end
    compared++; if (resp_err !== 1'b0) begin mismatched++; $display("[TB] FAIL sim_r1_err: got %h expected %h", resp_err, 1'b0); end
    tick();
  endtask

  // AWREADY immediate, WREADY three cycles late.
  task automatic test_wready_delay();
    $display("[TB] delayed WREADY");
    wDelay = 3;
    applyStimulus(2'b01, 2'b01, 32'hC, 32'h0, 32'h12345678, 32'h0);
    tick();
    applyStimulus(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    compared++; if ({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY} !== 3'b110) begin mismatched++; $display("[TB] FAIL wd_c1: got %b expected %b", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY}, 3'b110); end
    for (int i = 2; i <= 4; i++) begin
      tick();
      compared++; if ({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY} !== 3'b010) begin mismatched++; $display("[TB] FAIL wd_c%0d: got %b expected %b", i, {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY}, 3'b010); end
    end
    tick();
    compared++; if ({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY} !== 3'b001) begin mismatched++; $display("[TB] FAIL wd_c5: got %b expected %b", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY}, 3'b001); end
    tick(); tick();
    compared++; if (resp_valid !== 2'b01) begin mismatched++; $display("[TB] FAIL wd_resp: got %h expected %h", resp_valid, 2'b01); end
    compared++; if (mem[3] !== 32'h12345678) begin mismatched++; $display("[TB] FAIL wd_slave_mem: got %h expected %h", mem[3], 32'h12345678); end
    wDelay = 0;
    tick();
  endtask

  // Read at 0x8 answered with SLVERR and data 0xdead0011.
  task automatic test_read_error();
    $display("[TB] read with slave error");
    rRespCfg = RESP_SLVERR;
    useRdOvr = 1'b1;
    rdOvr    = 32'hDEAD0011;
    applyStimulus(2'b01, 2'b00, 32'h8, 32'h0, 32'h0, 32'h0);
    tick();
    applyStimulus(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    compared++; if ({M_AXI_ARVALID, M_AXI_ARADDR, M_AXI_ARPROT} !== {1'b1, 32'h8, 3'b000}) begin mismatched++; $display("[TB] FAIL re_ar: got %h expected %h", {M_AXI_ARVALID, M_AXI_ARADDR, M_AXI_ARPROT}, {1'b1, 32'h8, 3'b000}); end
    tick();
    compared++; if ({M_AXI_ARVALID, M_AXI_RREADY} !== 2'b01) begin mismatched++; $display("[TB] FAIL re_rd_phase: got %b expected %b", {M_AXI_ARVALID, M_AXI_RREADY}, 2'b01); end
    tick(); tick();
    compared++; if (resp_valid !== 2'b01) begin mismatched++; $display("[TB] FAIL re_resp_valid: got %h expected %h", resp_valid, 2'b01); end
    compared++; if (resp_err !== 1'b1) begin mismatched++; $display("[TB] FAIL re_resp_err: got %h expected %h", resp_err, 1'b1); end
    compared++; if (resp_rdata !== 32'hDEAD0011) begin mismatched++; $display("[TB] FAIL re_resp_rdata: got %h expected %h", resp_rdata, 32'hDEAD0011); end
    rRespCfg = RESP_OKAY;
    useRdOvr = 1'b0;
    tick();
  endtask

  // r1 reads the misaligned address 0x6: no bus activity, error response.
  task automatic test_misaligned();
    $display("[TB] misaligned read");
    applyStimulus(2'b10, 2'b00, 32'h0, 32'h6, 32'h0, 32'h0);
    #1;
    compared++; if (req_ready !== 2'b10) begin mismatched++; $display("[TB] FAIL mis_grant: got %h expected %h", req_ready, 2'b10); end
    tick();
    applyStimulus(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    compared++; if ({M_AXI_ARVALID, M_AXI_AWVALID, M_AXI_WVALID} !== 3'b000) begin mismatched++; $display("[TB] FAIL mis_no_bus: got %b expected %b", {M_AXI_ARVALID, M_AXI_AWVALID, M_AXI_WVALID}, 3'b000); end
    compared++; if (resp_valid !== 2'b00) begin mismatched++; $display("[TB] FAIL mis_resp_early: got %h expected %h", resp_valid, 2'b00); end
    tick();
    compared++; if (resp_valid !== 2'b10) begin mismatched++; $display("[TB] FAIL mis_resp_valid: got %h expected %h", resp_valid, 2'b10); end
    compared++; if (resp_err !== 1'b1) begin mismatched++; $display("[TB] FAIL mis_resp_err: got %h expected %h", resp_err, 1'b1); end
    compared++; if (resp_rdata !== 32'h0) begin mismatched++; $display("[TB] FAIL mis_resp_rdata: got %h expected %h", resp_rdata, 32'h0); end
    tick();
    compared++; if (resp_valid !== 2'b00) begin mismatched++; $display("[TB] FAIL mis_resp_pulse: got %h expected %h", resp_valid, 2'b00); end
  endtask

  // Reset lands while waiting in RD; afterwards a tie goes to r0 again.
  task automatic test_reset_mid();
    $display("[TB] reset during read");
    stallR = 1'b1;
    applyStimulus(2'b01, 2'b00, 32'h10, 32'h0, 32'h0, 32'h0);
    tick();
    applyStimulus(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    tick(); tick();
    compared++; if (M_AXI_RREADY !== 1'b1) begin mismatched++; $display("[TB] FAIL rm_in_rd: got %h expected %h", M_AXI_RREADY, 1'b1); end
    #2;
    ARESET = 1'b1;
    #1;
    compared++; if (M_AXI_RREADY !== 1'b0) begin mismatched++; $display("[TB] FAIL rm_rready: got %h expected %h", M_AXI_RREADY, 1'b0); end
    compared++; if (M_AXI_ARADDR !== 32'h0) begin mismatched++; $display("[TB] FAIL rm_araddr: got %h expected %h", M_AXI_ARADDR, 32'h0); end
    compared++; if ({resp_valid, req_ready} !== 4'b0000) begin mismatched++; $display("[TB] FAIL rm_handshakes: got %b expected %b", {resp_valid, req_ready}, 4'b0000); end
    stallR = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      compared++; if (resp_valid !== 2'b00) begin mismatched++; $display("[TB] FAIL rm_no_resp%0d: got %h expected %h", i, resp_valid, 2'b00); end
    end
    ARESET = 1'b0;
    tick();
    applyStimulus(2'b11, 2'b00, 32'h0, 32'h4, 32'h0, 32'h0);
    #1;
    compared++; if (req_ready !== 2'b01) begin mismatched++; $display("[TB] FAIL rm_regrant: got %h expected %h", req_ready, 2'b01); end
    tick();
    applyStimulus(2'b10, 2'b00, 32'h0, 32'h4, 32'h0, 32'h0);
    tick(); tick(); tick();
    compared++; if ({resp_valid, req_ready} !== 4'b0110) begin mismatched++; $display("[TB] FAIL rm_r0_done: got %b expected %b", {resp_valid, req_ready}, 4'b0110); end
    tick();
    applyStimulus(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    tick(); tick(); tick();
    compared++; if (resp_valid !== 2'b10) begin mismatched++; $display("[TB] FAIL rm_r1_done: got %h expected %h", resp_valid, 2'b10); end
    tick();
  endtask

  // Scenario sequence.
  initial begin
    ARESET    = 1'b1;
    req_valid = 2'b00;
    req_wr    = 2'b00;
    req_addr  = 64'h0;
    req_wdata = 64'h0;
    test_reset();
    test_single_write();
    test_simultaneous();
    test_wready_delay();
    test_read_error();
    test_misaligned();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
